serial_add_unit: RTL and testbench

Bit-serial adder sequencer built around the existing single-bit `full_adder` cell. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. Each cycle it feeds one bit pair, LSB first, into one `full_adder` instance and keeps the carry in a flop between cycles. It returns the WIDTH-bit sum, the carry-out and the signed overflow over a second valid/ready handshake. It is the low-area ALU add path for the CPU datapath.

---
 rtl/alu_pkg.sv | 12 +
 rtl/full_adder.sv | 16 +
 rtl/serial_add_unit.sv | 95 +++++++++
 tb/tb_serial_add_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types and defaults for the serial add path
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sau_state_t;

  localparam int SAU_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign sum  = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/serial_add_unit.sv
// rtl/serial_add_unit.sv - bit-serial adder sequencer, LSB first, one full_adder
module serial_add_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = SAU_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sau_state_t       state_q;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry_q;
  logic             cout_q;
  logic             overflow_q;
  logic [CW-1:0]    bit_cnt;

  logic fa_sum;
  logic fa_cout;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      sum_sr     <= '0;
      carry_q    <= 1'b0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sr    <= a;
            b_sr    <= b;
            sum_sr  <= '0;
            carry_q <= cin;
            bit_cnt <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          sum_sr  <= {fa_sum, sum_sr[WIDTH-1:1]};
          carry_q <= fa_cout;
          bit_cnt <= bit_cnt + 1'b1;
          // carry_q here is still the carry into the MSB
          if (bit_cnt == LAST_BIT) begin
            overflow_q <= carry_q ^ fa_cout;
            cout_q     <= fa_cout;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_sr;
  assign cout      = cout_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_add_unit.sv
// tb/tb_serial_add_unit.sv - directed self-checking bench for serial_add_unit
module tb_serial_add_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       overflow;

  int checks;
  int failures;

  serial_add_unit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accepts one add and waits until the result is presented (left in DONE).
  task automatic run_add(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                         input bit scramble, output int lat);
    check("in_ready_before_accept", in_ready, 1);
    a = av;
    b = bv;
    cin = cv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!scramble) in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (scramble) begin
        a = 8'($urandom);
        b = 8'($urandom);
        cin = ~cin;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic pop_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bubble_in_ready", in_ready, 1);
    check("bubble_out_valid", out_valid, 0);
  endtask

  task automatic add_and_check(input string tag, input logic [7:0] av, input logic [7:0] bv,
                               input logic cv, input logic [7:0] es, input logic ec,
                               input logic ev);
    int lat;
    run_add(av, bv, cv, 1'b0, lat);
    check({tag, "_latency"}, lat, 8);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_overflow"}, overflow, ev);
    pop_result();
  endtask

  initial begin
    int lat;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_sum", sum, 0);
    check("reset_cout", cout, 0);
    check("reset_overflow", overflow, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    add_and_check("add_3c_05", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);
    add_and_check("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    add_and_check("add_00_00_c1", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    add_and_check("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    add_and_check("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

    // Back-pressure: result must hold while out_ready stays low
    run_add(8'h12, 8'h34, 1'b0, 1'b0, lat);
    check("bp_latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_sum", sum, 8'h46);
      check("bp_cout", cout, 0);
      check("bp_overflow", overflow, 0);
      @(posedge clk);
      #1;
    end
    pop_result();
    add_and_check("bp_second_55_2a_c1", 8'h55, 8'h2A, 1'b1, 8'h80, 1'b0, 1'b1);

    // Operand changes after the accept edge must not leak in
    run_add(8'h10, 8'h20, 1'b0, 1'b1, lat);
    check("scr_latency", lat, 8);
    check("scr_sum", sum, 8'h30);
    check("scr_cout", cout, 0);
    check("scr_overflow", overflow, 0);
    pop_result();

    // Asynchronous reset after the 3rd shift edge
    a = 8'hAA;
    b = 8'h55;
    cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("rst_mid_in_ready_shift", in_ready, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_out_valid", out_valid, 0);
    check("rst_async_in_ready", in_ready, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("rst_after_out_valid", out_valid, 0);
    end
    check("rst_after_in_ready", in_ready, 1);
    add_and_check("post_rst_01_02", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
